// File: rtl/watch_pkg.sv
// watch_pkg: shared watch types, field limits and wrap helpers used by the alarm and the timekeeper
package watch_pkg;
  typedef enum logic [2:0] {IDLE, SETH, SETM, RING, SNOOZE} alm_state_e;
  localparam int HRS_MAX = 23;
  localparam int MS_MAX = 59;
  function automatic logic [6:0] plus1(input logic [6:0] v, input logic [6:0] max);
    return (v >= max) ? 7'd0 : v + 7'd1;
  endfunction
  function automatic logic [6:0] minus1(input logic [6:0] v, input logic [6:0] max);
    return (v == 7'd0) ? max : v - 7'd1;
  endfunction
endpackage

// File: rtl/alm_field_adj.sv
// alm_field_adj: wrapping up/down register for one alarm field (0..MAX)
// clk, rst (sync active-low) ; en gates edits ; inc/dec step by one, both together hold ; val is the field value
module alm_field_adj
  import watch_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int MAX = 59,
  parameter int RST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] val
);
  always_ff @(posedge clk)
    if (!rst) val <= WIDTH'(RST);
    else if (en && (inc ^ dec))
      val <= WIDTH'(inc ? plus1(7'(val), 7'(MAX)) : minus1(7'(val), 7'(MAX)));
endmodule

// File: rtl/watch_alarm_ctrl.sv
// watch_alarm_ctrl: alarm setting, time match and ring/snooze/dismiss sequencing for the wrist-watch core
// clk, rst (sync active-low) ; hrs/min/sec/time_run from the timekeeper ; alarm_en level enable
// alarm_set/next/inc/dec edit buttons ; snooze/dismiss user requests
// alm_hrs/alm_min alarm setting ; buzzer ring output ; editing 01 hours / 10 minutes
// snooze_cnt snoozes used this event ; missed sticky ring-timeout flag
module watch_alarm_ctrl
  import watch_pkg::*;
#(
  parameter int RING_SECS = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int ALM_H_RST = 6,
  parameter int ALM_M_RST = 0,
  localparam int TW = $clog2(RING_SECS > SNOOZE_SECS ? RING_SECS : SNOOZE_SECS),
  localparam int CW = $clog2(MAX_SNOOZE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    hrs,
  input  logic [5:0]    min,
  input  logic [5:0]    sec,
  input  logic          time_run,
  input  logic          alarm_en,
  input  logic          alarm_set,
  input  logic          next,
  input  logic          inc,
  input  logic          dec,
  input  logic          snooze,
  input  logic          dismiss,
  output logic [4:0]    alm_hrs,
  output logic [5:0]    alm_min,
  output logic          buzzer,
  output logic [1:0]    editing,
  output logic [CW-1:0] snooze_cnt,
  output logic          missed
);
  localparam logic [TW-1:0] RING_LD = TW'(RING_SECS - 1);
  localparam logic [TW-1:0] SNZ_LD = TW'(SNOOZE_SECS - 1);
  alm_state_e state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [CW-1:0] cnt_n;
  logic missed_n, match;
  assign match = alarm_en & time_run & (hrs == alm_hrs) & (min == alm_min) & (sec == 6'd0);
  alm_field_adj #(.WIDTH(5), .MAX(HRS_MAX), .RST(ALM_H_RST)) u_hrs (
    .clk(clk), .rst(rst), .en(state == SETH && !next), .inc(inc), .dec(dec), .val(alm_hrs)
  );
  alm_field_adj #(.WIDTH(6), .MAX(MS_MAX), .RST(ALM_M_RST)) u_min (
    .clk(clk), .rst(rst), .en(state == SETM && !next), .inc(inc), .dec(dec), .val(alm_min)
  );
  always_comb begin
    state_n = state;
    timer_n = timer;
    cnt_n = snooze_cnt;
    missed_n = missed & ~alarm_set & ~dismiss;
    case (state)
      IDLE:
        if (alarm_set) state_n = SETH;
        else if (match) begin
          state_n = RING;
          timer_n = RING_LD;
          cnt_n = '0;
        end
      SETH: state_n = alarm_set ? IDLE : next ? SETM : SETH;
      SETM: state_n = (alarm_set || next) ? IDLE : SETM;
      RING:
        if (!alarm_en || dismiss) state_n = IDLE;
        else if (snooze && snooze_cnt < CW'(MAX_SNOOZE)) begin
          state_n = SNOOZE;
          timer_n = SNZ_LD;
          cnt_n = snooze_cnt + CW'(1);
        end else if (timer == '0) begin
          state_n = IDLE;
          missed_n = 1'b1;
        end else timer_n = timer - TW'(1);
      SNOOZE:
        if (!alarm_en || dismiss) state_n = IDLE;
        else if (timer == '0) begin
          state_n = RING;
          timer_n = RING_LD;
        end else timer_n = timer - TW'(1);
      default: state_n = IDLE;
    endcase
  end
  // buzzer is a registered decode of the current state, so it follows RING one edge later
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      snooze_cnt <= '0;
      missed <= 1'b0;
      buzzer <= 1'b0;
      editing <= 2'b00;
    end else begin
      state <= state_n;
      timer <= timer_n;
      snooze_cnt <= cnt_n;
      missed <= missed_n;
      buzzer <= state == RING;
      editing <= state_n == SETH ? 2'b01 : state_n == SETM ? 2'b10 : 2'b00;
    end
endmodule
